// File: rtl/super_pkg.sv
// ============================================================================
// super_pkg : shared data-memory port types and widths
// Revision  : 1.0
// ============================================================================
`default_nettype none

package super_pkg;

  localparam int unsigned MemW = 65;

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic            is_cap;
    logic [31:0]     addr;
    logic [MemW-1:0] wdata;
  } dmem_req_t;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_AUX = 1'b1
  } dmem_owner_e;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_owner_fifo.sv
// ============================================================================
// dmem_owner_fifo : in-order owner-id FIFO with simultaneous push/pop
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dmem_owner_fifo
  import super_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  dmem_owner_e              owner_i,
  input  logic                     pop_i,
  output dmem_owner_e              head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign count_o = cnt_q;
  assign head_o  = dmem_owner_e'(mem_q[rptr_q]);

  // A push into a full FIFO is accepted only when the head leaves this cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= owner_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// dmem_port_arbiter : shares the core data-memory port between LSU and aux
// Revision          : 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter
  import super_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned StarveLimit    = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            p0_req_i,
  input  logic            p0_we_i,
  input  logic [3:0]      p0_be_i,
  input  logic            p0_is_cap_i,
  input  logic [31:0]     p0_addr_i,
  input  logic [MemW-1:0] p0_wdata_i,
  input  logic            p1_req_i,
  input  logic            p1_we_i,
  input  logic [3:0]      p1_be_i,
  input  logic            p1_is_cap_i,
  input  logic [31:0]     p1_addr_i,
  input  logic [MemW-1:0] p1_wdata_i,
  output logic            p0_gnt_o,
  output logic            p0_rvalid_o,
  output logic            p0_err_o,
  output logic [MemW-1:0] p0_rdata_o,
  output logic            p1_gnt_o,
  output logic            p1_rvalid_o,
  output logic            p1_err_o,
  output logic [MemW-1:0] p1_rdata_o,
  output logic            data_req_o,
  output logic            data_we_o,
  output logic [3:0]      data_be_o,
  output logic            data_is_cap_o,
  output logic [31:0]     data_addr_o,
  output logic [MemW-1:0] data_wdata_o,
  input  logic            data_gnt_i,
  input  logic            data_rvalid_i,
  input  logic            data_err_i,
  input  logic [MemW-1:0] data_rdata_i,
  output logic            proto_err_o,
  output logic            outstanding_o
);

  localparam int unsigned CntW      = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(StarveLimit);

  arb_state_e             state_q, state_d;
  logic [CntW-1:0]        starve_q, starve_d;
  logic                   proto_err_q, proto_err_d;
  logic                   drive, granted, pop, can_issue;
  dmem_owner_e            sel, head;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(MaxOutstanding):0] fifo_count;
  dmem_req_t              p0_r, p1_r, bus_r;

  assign p0_r = '{we: p0_we_i, be: p0_be_i, is_cap: p0_is_cap_i, addr: p0_addr_i, wdata: p0_wdata_i};
  assign p1_r = '{we: p1_we_i, be: p1_be_i, is_cap: p1_is_cap_i, addr: p1_addr_i, wdata: p1_wdata_i};

  assign pop       = data_rvalid_i & ~fifo_empty;
  assign can_issue = ~fifo_full | pop;

  always_comb begin
    state_d = state_q;
    drive   = 1'b0;
    sel     = OWN_LSU;
    case (state_q)
      ARB: begin
        if (can_issue && (p0_req_i || p1_req_i)) begin
          drive = 1'b1;
          sel   = (p1_req_i && (!p0_req_i || starve_q == StarveMax)) ? OWN_AUX : OWN_LSU;
          if (!data_gnt_i) state_d = (sel == OWN_AUX) ? HOLD1 : HOLD0;
        end
      end
      HOLD0: begin
        drive = 1'b1;
        sel   = OWN_LSU;
        if (data_gnt_i) state_d = ARB;
      end
      HOLD1: begin
        drive = 1'b1;
        sel   = OWN_AUX;
        if (data_gnt_i) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign granted = drive & data_gnt_i;

  // Starvation only accrues while port 1 is actually waiting
  always_comb begin
    starve_d = starve_q;
    if (!p1_req_i)
      starve_d = '0;
    else if (granted && sel == OWN_AUX)
      starve_d = '0;
    else if (granted && starve_q != StarveMax)
      starve_d = starve_q + 1'b1;
  end

  assign proto_err_d = proto_err_q | (data_rvalid_i & fifo_empty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
    end
  end

  dmem_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (granted),
    .owner_i (sel),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus_r         = drive ? ((sel == OWN_AUX) ? p1_r : p0_r) : '0;
  assign data_req_o    = drive;
  assign data_we_o     = bus_r.we;
  assign data_be_o     = bus_r.be;
  assign data_is_cap_o = bus_r.is_cap;
  assign data_addr_o   = bus_r.addr;
  assign data_wdata_o  = bus_r.wdata;

  assign p0_gnt_o    = granted & (sel == OWN_LSU);
  assign p1_gnt_o    = granted & (sel == OWN_AUX);
  assign p0_rvalid_o = pop & (head == OWN_LSU);
  assign p1_rvalid_o = pop & (head == OWN_AUX);
  assign p0_err_o    = p0_rvalid_o & data_err_i;
  assign p1_err_o    = p1_rvalid_o & data_err_i;
  assign p0_rdata_o  = data_rdata_i;
  assign p1_rdata_o  = data_rdata_i;

  assign proto_err_o   = proto_err_q;
  assign outstanding_o = (fifo_count != '0);

endmodule

`default_nettype wire
